// File: rtl/fdn_chan_serializer.sv
// fdn_chan_serializer: ping-pong buffers parallel complex snapshots and streams
// them one channel per cycle, flagging the final sample of each frame block.
module fdn_chan_serializer #(
  parameter int wight_data_i = 25,
  parameter int N_chanals    = 32,
  parameter int N_frames     = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              snap_vld,
  input  logic [N_chanals*wight_data_i-1:0] snapReIn,
  input  logic [N_chanals*wight_data_i-1:0] snapImIn,
  input  logic                              abort,
  input  logic                              ovf_clr,
  output logic                              vld_data_out,
  output logic                              last_data_out,
  output logic [wight_data_i-1:0]           dataReOut,
  output logic [wight_data_i-1:0]           dataImOut,
  output logic                              busy,
  output logic                              ovf
);
  localparam int W  = wight_data_i;
  localparam int BW = N_chanals * W;
  localparam int CW = (N_chanals > 1) ? $clog2(N_chanals) : 1;
  localparam int FW = (N_frames > 1) ? $clog2(N_frames) : 1;
  localparam logic [CW-1:0] CHAN_LAST  = CW'(N_chanals - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(N_frames - 1);

  // Output stream: vld_data_out qualifies dataReOut/dataImOut/last_data_out each
  // cycle; there is no ready, the consumer must accept every valid sample.
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [1:0]         full_q, full_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      chan_q, chan_d;
  logic [FW-1:0]      frame_q, frame_d;
  logic               ovf_q, ovf_d;
  logic               vld_q, vld_d;
  logic               last_q, last_d;
  logic [W-1:0]       re_q, re_d;
  logic [W-1:0]       im_q, im_d;
  logic [1:0][BW-1:0] bank_re_q, bank_re_d;
  logic [1:0][BW-1:0] bank_im_q, bank_im_d;
  logic               release_bank;
  logic               can_write;
  logic               accept;
  logic               drop;

  always_comb begin
    state_d      = state_q;
    full_d       = full_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    chan_d       = chan_q;
    frame_d      = frame_q;
    vld_d        = 1'b0;
    last_d       = 1'b0;
    re_d         = re_q;
    im_d         = im_q;
    bank_re_d    = bank_re_q;
    bank_im_d    = bank_im_q;
    release_bank = 1'b0;

    case (state_q)
      IDLE: begin
        if (full_q[rd_ptr_q]) begin
          state_d = SEND;
          chan_d  = '0;
        end
      end
      SEND: begin
        vld_d  = 1'b1;
        re_d   = bank_re_q[rd_ptr_q][int'(chan_q)*W +: W];
        im_d   = bank_im_q[rd_ptr_q][int'(chan_q)*W +: W];
        last_d = (chan_q == CHAN_LAST) && (frame_q == FRAME_LAST);
        if (chan_q == CHAN_LAST) begin
          release_bank     = 1'b1;
          full_d[rd_ptr_q] = 1'b0;
          rd_ptr_d         = ~rd_ptr_q;
          chan_d           = '0;
          frame_d          = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
          // Back-to-back frames only when the other bank is already loaded.
          if (!full_q[~rd_ptr_q]) state_d = IDLE;
        end else begin
          chan_d = chan_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A bank being drained on its last channel may be refilled on the same edge.
    can_write = !full_q[wr_ptr_q] || (release_bank && (rd_ptr_q == wr_ptr_q));
    accept    = snap_vld && can_write && !abort;
    drop      = snap_vld && !can_write && !abort;

    if (accept) begin
      full_d[wr_ptr_q]    = 1'b1;
      wr_ptr_d            = ~wr_ptr_q;
      bank_re_d[wr_ptr_q] = snapReIn;
      bank_im_d[wr_ptr_q] = snapImIn;
    end

    ovf_d = drop || (ovf_q && !ovf_clr);

    if (abort) begin
      state_d  = IDLE;
      full_d   = '0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      chan_d   = '0;
      frame_d  = '0;
      vld_d    = 1'b0;
      last_d   = 1'b0;
      re_d     = '0;
      im_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      full_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      chan_q   <= '0;
      frame_q  <= '0;
      ovf_q    <= 1'b0;
      vld_q    <= 1'b0;
      last_q   <= 1'b0;
      re_q     <= '0;
      im_q     <= '0;
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      chan_q   <= chan_d;
      frame_q  <= frame_d;
      ovf_q    <= ovf_d;
      vld_q    <= vld_d;
      last_q   <= last_d;
      re_q     <= re_d;
      im_q     <= im_d;
    end
  end

  // Bank contents are only meaningful while the matching full flag is set.
  always_ff @(posedge clk) begin
    bank_re_q <= bank_re_d;
    bank_im_q <= bank_im_d;
  end

  assign vld_data_out  = vld_q;
  assign last_data_out = last_q;
  assign dataReOut     = re_q;
  assign dataImOut     = im_q;
  assign ovf           = ovf_q;
  assign busy          = (state_q == SEND) || (|full_q);

endmodule

// File: tb/tb_fdn_chan_serializer.sv
// Bench for fdn_chan_serializer: table-driven single snapshots plus hand-written
// sequences for back-to-back, overflow, abort and async reset cases.
module tb_fdn_chan_serializer;
  localparam int W  = 25;
  localparam int N  = 4;
  localparam int F  = 2;
  localparam int BW = N * W;

  typedef logic [W-1:0]  samp_t;
  typedef logic [BW-1:0] bus_t;
  typedef struct {
    bus_t re;
    bus_t im;
    logic exp_last;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  logic  snap_vld = 1'b0;
  logic  abort = 1'b0;
  logic  ovf_clr = 1'b0;
  bus_t  snapReIn = '0;
  bus_t  snapImIn = '0;
  logic  vld_data_out;
  logic  last_data_out;
  samp_t dataReOut;
  samp_t dataImOut;
  logic  busy;
  logic  ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int run_len  = 0;
  int last_run = 0;
  logic [2*W:0] exp_q[$];
  logic [2*W:0] mon_item;
  vec_t vecs[4];

  fdn_chan_serializer #(
    .wight_data_i(W),
    .N_chanals   (N),
    .N_frames    (F)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .snap_vld     (snap_vld),
    .snapReIn     (snapReIn),
    .snapImIn     (snapImIn),
    .abort        (abort),
    .ovf_clr      (ovf_clr),
    .vld_data_out (vld_data_out),
    .last_data_out(last_data_out),
    .dataReOut    (dataReOut),
    .dataImOut    (dataImOut),
    .busy         (busy),
    .ovf          (ovf)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bus_t pack(input samp_t s0, input samp_t s1, input samp_t s2, input samp_t s3);
    return {s3, s2, s1, s0};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one snapshot strobe; returns just after the capturing edge.
  task automatic drive_snap(input bus_t re, input bus_t im, input bit accepted, input logic last_exp);
    snapReIn = re;
    snapImIn = im;
    snap_vld = 1'b1;
    if (accepted) begin
      for (int c = 0; c < N; c++)
        exp_q.push_back({((c == N - 1) ? last_exp : 1'b0), re[c*W +: W], im[c*W +: W]});
    end
    tick(1);
    snap_vld = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i = 0;
    while (exp_q.size() != 0 && i < 200) begin
      tick(1);
      i++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    tick(2);
  endtask

  // Scoreboard: every valid output sample pops one expected entry.
  always @(negedge clk) begin
    if (rst) begin
      run_len = 0;
    end else if (vld_data_out) begin
      run_len++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_vld: got re=%0h im=%0h with no expected sample", dataReOut, dataImOut);
      end else begin
        mon_item = exp_q.pop_front();
        check("stream", 64'({last_data_out, dataReOut, dataImOut}), 64'(mon_item));
      end
    end else begin
      check("last_without_vld", 64'(last_data_out), 64'd0);
      if (run_len != 0) begin
        last_run = run_len;
        run_len  = 0;
      end
    end
  end

  initial begin
    vecs[0].re = pack(25'd1, 25'd2, 25'd3, 25'd4);
    vecs[0].im = pack(samp_t'(-1), samp_t'(-2), samp_t'(-3), samp_t'(-4));
    vecs[0].exp_last = 1'b0;
    vecs[1].re = pack(25'h1FFFFFF, 25'h0, 25'h1000000, 25'h0AAAAAA);
    vecs[1].im = pack(25'h0555555, 25'h1FFFFFE, 25'h1, 25'h1234567);
    vecs[1].exp_last = 1'b1;
    for (int i = 2; i < 4; i++) begin
      vecs[i].re = pack(samp_t'($urandom_range(1, 33554431)), samp_t'($urandom_range(0, 33554431)),
                        samp_t'($urandom_range(0, 33554431)), samp_t'($urandom_range(0, 33554431)));
      vecs[i].im = pack(samp_t'($urandom_range(0, 33554431)), samp_t'($urandom_range(0, 33554431)),
                        samp_t'($urandom_range(0, 33554431)), samp_t'($urandom_range(0, 33554431)));
      vecs[i].exp_last = (i == 3);
    end

    // Reset
    #1 rst = 1'b1;
    #1;
    check("rst_vld", 64'(vld_data_out), 64'd0);
    check("rst_last", 64'(last_data_out), 64'd0);
    check("rst_re", 64'(dataReOut), 64'd0);
    check("rst_im", 64'(dataImOut), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tick(1);

    // Isolated snapshots: latency, ordering, frame parity of last
    for (int i = 0; i < 4; i++) begin
      drive_snap(vecs[i].re, vecs[i].im, 1'b1, vecs[i].exp_last);
      check("busy_after_capture", 64'(busy), 64'd1);
      tick(1);
      check("latency_edge1_vld", 64'(vld_data_out), 64'd0);
      tick(1);
      check("latency_edge2_vld", 64'(vld_data_out), 64'd1);
      check("latency_edge2_re", 64'(dataReOut), 64'(vecs[i].re[W-1:0]));
      wait_drain("drain_single");
      check("single_run", 64'(last_run), 64'(N));
      check("single_busy_idle", 64'(busy), 64'd0);
      check("single_ovf", 64'(ovf), 64'd0);
    end

    // Two snapshots 4 cycles apart: one contiguous 8-sample block, last at the end
    drive_snap(pack(25'd10, 25'd11, 25'd12, 25'd13), pack(25'd20, 25'd21, 25'd22, 25'd23), 1'b1, 1'b0);
    tick(3);
    drive_snap(pack(25'd14, 25'd15, 25'd16, 25'd17), pack(25'd24, 25'd25, 25'd26, 25'd27), 1'b1, 1'b1);
    wait_drain("drain_pair");
    check("pair_run", 64'(last_run), 64'd8);

    // Three consecutive strobes: third dropped, then ovf_clr behaviour
    drive_snap(pack(25'd30, 25'd31, 25'd32, 25'd33), pack(25'd40, 25'd41, 25'd42, 25'd43), 1'b1, 1'b0);
    check("ovf_before_drop", 64'(ovf), 64'd0);
    drive_snap(pack(25'd34, 25'd35, 25'd36, 25'd37), pack(25'd44, 25'd45, 25'd46, 25'd47), 1'b1, 1'b1);
    drive_snap(pack(25'd50, 25'd51, 25'd52, 25'd53), pack(25'd60, 25'd61, 25'd62, 25'd63), 1'b0, 1'b0);
    check("ovf_after_drop", 64'(ovf), 64'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", 64'(ovf), 64'd0);
    wait_drain("drain_triple");
    check("triple_run", 64'(last_run), 64'd8);

    drive_snap(pack(25'd70, 25'd71, 25'd72, 25'd73), pack(25'd80, 25'd81, 25'd82, 25'd83), 1'b1, 1'b0);
    drive_snap(pack(25'd74, 25'd75, 25'd76, 25'd77), pack(25'd84, 25'd85, 25'd86, 25'd87), 1'b1, 1'b1);
    drive_snap(pack(25'd90, 25'd91, 25'd92, 25'd93), pack(25'd94, 25'd95, 25'd96, 25'd97), 1'b0, 1'b0);
    check("ovf_second_drop", 64'(ovf), 64'd1);
    ovf_clr = 1'b1;
    drive_snap(pack(25'd98, 25'd99, 25'd100, 25'd101), pack(25'd1, 25'd1, 25'd1, 25'd1), 1'b0, 1'b0);
    ovf_clr = 1'b0;
    check("ovf_drop_beats_clr", 64'(ovf), 64'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_cleared_again", 64'(ovf), 64'd0);
    wait_drain("drain_clr");

    // Both banks full, refill of bank 0 on the edge its last channel goes out
    drive_snap(pack(25'd110, 25'd111, 25'd112, 25'd113), pack(25'd120, 25'd121, 25'd122, 25'd123), 1'b1, 1'b0);
    drive_snap(pack(25'd114, 25'd115, 25'd116, 25'd117), pack(25'd124, 25'd125, 25'd126, 25'd127), 1'b1, 1'b1);
    tick(3);
    drive_snap(pack(25'd130, 25'd131, 25'd132, 25'd133), pack(25'd140, 25'd141, 25'd142, 25'd143), 1'b1, 1'b0);
    check("refill_no_ovf", 64'(ovf), 64'd0);
    wait_drain("drain_refill");
    check("refill_run", 64'(last_run), 64'd12);
    check("refill_ovf_end", 64'(ovf), 64'd0);

    // Abort while streaming channel 2; frame counter restarts
    drive_snap(pack(25'd150, 25'd151, 25'd152, 25'd153), pack(25'd160, 25'd161, 25'd162, 25'd163), 1'b1, 1'b1);
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_vld", 64'(vld_data_out), 64'd0);
    check("abort_last", 64'(last_data_out), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_pending", 64'(exp_q.size()), 64'd2);
    exp_q.delete();
    tick(2);
    drive_snap(pack(25'd170, 25'd171, 25'd172, 25'd173), pack(25'd180, 25'd181, 25'd182, 25'd183), 1'b1, 1'b0);
    tick(3);
    drive_snap(pack(25'd174, 25'd175, 25'd176, 25'd177), pack(25'd184, 25'd185, 25'd186, 25'd187), 1'b1, 1'b1);
    wait_drain("drain_post_abort");
    check("post_abort_run", 64'(last_run), 64'd8);

    // Asynchronous reset mid-stream with ovf set
    drive_snap(pack(25'd200, 25'd201, 25'd202, 25'd203), pack(25'd210, 25'd211, 25'd212, 25'd213), 1'b1, 1'b0);
    drive_snap(pack(25'd204, 25'd205, 25'd206, 25'd207), pack(25'd214, 25'd215, 25'd216, 25'd217), 1'b1, 1'b1);
    drive_snap(pack(25'd220, 25'd221, 25'd222, 25'd223), pack(25'd230, 25'd231, 25'd232, 25'd233), 1'b0, 1'b0);
    check("pre_rst_ovf", 64'(ovf), 64'd1);
    tick(1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_vld", 64'(vld_data_out), 64'd0);
    check("async_rst_last", 64'(last_data_out), 64'd0);
    check("async_rst_re", 64'(dataReOut), 64'd0);
    check("async_rst_im", 64'(dataImOut), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_ovf", 64'(ovf), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    tick(1);
    drive_snap(pack(25'd240, 25'd241, 25'd242, 25'd243), pack(25'd250, 25'd251, 25'd252, 25'd253), 1'b1, 1'b0);
    wait_drain("drain_post_rst");
    check("post_rst_run", 64'(last_run), 64'(N));
    check("post_rst_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fdn_chan_serializer.md
Name: fdn_chan_serializer

Overview:
- Source-side companion of the FDN core: converts parallel multichannel complex snapshots into the time-multiplexed channel stream the core consumes (vld/last/Re/Im, channel 0..N_chanals-1 back-to-back).
- Ping-pong buffers two snapshots, streams each as N_chanals consecutive valid samples and marks the final sample of every N_frames-snapshot accumulation block with last.

Parameters:
- wight_data_i, 25, bit width of each Re/Im sample.
- N_chanals, 32, channels per snapshot; power of two, >=2.
- N_frames, 16, snapshots per accumulation block; >=1.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- snap_vld  in  1  one-cycle strobe; snapReIn/snapImIn hold a valid snapshot
- snapReIn  in  N_chanals*wight_data_i  Re samples; channel k at bits [k*wight_data_i +: wight_data_i]
- snapImIn  in  N_chanals*wight_data_i  Im samples, same packing
- abort  in  1  synchronous flush of buffers, counters and state
- ovf_clr  in  1  clears sticky overflow flag
- vld_data_out  out  1  output sample valid
- last_data_out  out  1  final sample of an accumulation block
- dataReOut  out  wight_data_i  Re of current channel
- dataImOut  out  wight_data_i  Im of current channel
- busy  out  1  high while in SEND or any bank is full
- ovf  out  1  sticky: snapshot was dropped

Behaviour:
- Reset (async) or abort (sync): both bank-full flags, wr_ptr, rd_ptr, chan counter and frame counter go to 0; state IDLE. vld_data_out, last_data_out, dataReOut, dataImOut and busy are 0. ovf is cleared by rst only; abort leaves ovf unchanged.
- Capture: on snap_vld, write the bus into bank[wr_ptr] if that bank is not full, or if it is being released in the same cycle. Then set its full flag and toggle wr_ptr. Otherwise drop the snapshot and set ovf.
- ovf_clr clears ovf. A drop in the same cycle as ovf_clr wins, so ovf stays 1.
- FSM IDLE: if bank[rd_ptr] is full, go to SEND with chan=0.
- FSM SEND: every cycle, register vld_data_out=1 and data = bank[rd_ptr][chan], then increment chan.
- At chan==N_chanals-1: release bank[rd_ptr] (clear full), toggle rd_ptr, increment the frame counter (wraps at N_frames), reset chan to 0.
  - If the other bank is full, stay in SEND with no bubble.
  - Otherwise go to IDLE.
- Output is registered. A snapshot captured at edge k while IDLE with both banks empty produces channel 0 valid after edge k+2. Channel n follows at edge k+2+n.
- last_data_out=1 only together with the channel N_chanals-1 sample of frame index N_frames-1. With N_frames=1, every frame's final sample carries last.
- Outside valid cycles: vld_data_out=0, last_data_out=0, data holds its previous value.
- No backpressure. Sustained throughput is one snapshot per N_chanals cycles. Faster input overflows after two buffered snapshots.
- Abort during SEND: the stream stops at the next edge, with no partial last. The next block starts at frame 0, chan 0.
- Counters are log2(N_chanals) and log2(N_frames) bits (min 1), wrap-safe.

Test Plan:
- N_chanals=4, N_frames=2. One snapshot with Re=1,2,3,4, Im=-1..-4 -> vld for 4 cycles starting 2 cycles after the strobe; data in order 1,2,3,4 / -1..-4; last=0; busy then falls to 0.
- N_chanals=4, N_frames=2. Two snapshots 4 cycles apart -> 8 contiguous valid cycles; last=1 only on the 8th; frame counter back to 0.
- Three snap_vld on consecutive cycles -> first two streamed; third dropped; ovf=1. ovf_clr -> ovf=0. ovf_clr coincident with a new drop -> ovf stays 1.
- Both banks full; snap_vld in the cycle channel 3 of bank 0 is sent -> snapshot accepted into bank 0; 12 contiguous valid samples; no ovf.
- abort asserted at chan=2 -> vld=0 next cycle; no last; the next snapshot starts at channel 0 with frame 0; last appears after 2 full frames.
- rst asserted mid-SEND, asynchronously between edges -> all outputs 0 immediately; ovf=0; a fresh snapshot streams normally after release.
